// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit, one radix-2 step per
//               cycle, start/ready request side and valid/ack result side.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Start,
    output logic                  Ready,
    input  logic [2:0]            MDUControl,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic                  Flush,
    output logic                  Valid,
    input  logic                  Ack,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  DivByZero
);

    localparam int                    c_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [c_CNT_W-1:0]    c_LAST  = c_CNT_W'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] c_MIN   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [c_CNT_W-1:0]    r_count;
    logic [2:0]            r_op;
    logic [DATA_WIDTH-1:0] r_hi;
    logic [DATA_WIDTH-1:0] r_lo;
    logic [DATA_WIDTH-1:0] r_opb;
    logic                  r_neg_p;
    logic                  r_neg_a;
    logic                  r_pend_dbz;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_dbz;

    logic                  w_accept;
    logic                  w_sgn_a;
    logic                  w_sgn_b;
    logic                  w_neg_a;
    logic                  w_neg_b;
    logic [DATA_WIDTH-1:0] w_mag_a;
    logic [DATA_WIDTH-1:0] w_mag_b;
    logic                  w_b_zero;
    logic                  w_ovf;
    logic                  w_special;
    logic [DATA_WIDTH-1:0] w_special_res;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH:0]   w_diff;
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [2*DATA_WIDTH-1:0] w_prod_fix;
    logic [DATA_WIDTH-1:0] w_quo;
    logic [DATA_WIDTH-1:0] w_rem;
    logic [DATA_WIDTH-1:0] w_final;

    assign Ready     = (r_state == c_IDLE);
    assign Valid     = r_valid;
    assign Result    = r_result;
    assign DivByZero = r_dbz;

    assign w_accept = Start && (r_state == c_IDLE) && !Flush;

    // Signed rs1: MUL, MULH, MULHSU, DIV, REM. Signed rs2: MUL, MULH, DIV, REM.
    assign w_sgn_a = MDUControl[2] ? !MDUControl[0] : (MDUControl != 3'b011);
    assign w_sgn_b = MDUControl[2] ? !MDUControl[0] : !MDUControl[1];
    assign w_neg_a = w_sgn_a && SrcA[DATA_WIDTH-1];
    assign w_neg_b = w_sgn_b && SrcB[DATA_WIDTH-1];
    assign w_mag_a = w_neg_a ? -SrcA : SrcA;
    assign w_mag_b = w_neg_b ? -SrcB : SrcB;

    assign w_b_zero  = (SrcB == '0);
    assign w_ovf     = !MDUControl[0] && (SrcA == c_MIN) && (SrcB == '1);
    assign w_special = MDUControl[2] && (w_b_zero || w_ovf);

    always_comb begin
        w_special_res = '0;
        if (w_b_zero) w_special_res = MDUControl[1] ? SrcA : '1;
        else          w_special_res = MDUControl[1] ? '0 : SrcA;
    end

    // r_hi holds the partial product high half / partial remainder,
    // r_lo the remaining multiplier bits / dividend-then-quotient bits.
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    assign w_shift = {r_hi, r_lo[DATA_WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_opb};

    assign w_prod     = {r_hi, r_lo};
    assign w_prod_fix = r_neg_p ? -w_prod : w_prod;
    assign w_quo      = r_neg_p ? -r_lo : r_lo;
    assign w_rem      = r_neg_a ? -r_hi : r_hi;

    always_comb begin
        w_final = '0;
        case (r_op)
            3'b000:                 w_final = w_prod_fix[DATA_WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            3'b100, 3'b101:         w_final = w_quo;
            default:                w_final = w_rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_count    <= '0;
            r_op       <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_opb      <= '0;
            r_neg_p    <= 1'b0;
            r_neg_a    <= 1'b0;
            r_pend_dbz <= 1'b0;
            r_valid    <= 1'b0;
            r_result   <= '0;
            r_dbz      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_op    <= MDUControl;
                        r_opb   <= w_mag_b;
                        r_neg_p <= w_neg_a ^ w_neg_b;
                        r_neg_a <= w_neg_a;
                        r_count <= '0;
                        if (w_special) begin
                            r_state    <= c_DONE;
                            r_hi       <= w_special_res;
                            r_lo       <= '0;
                            r_pend_dbz <= w_b_zero;
                        end else begin
                            r_state    <= c_CALC;
                            r_hi       <= '0;
                            r_lo       <= w_mag_a;
                            r_pend_dbz <= 1'b0;
                        end
                    end
                end
                c_CALC: begin
                    if (Flush) begin
                        r_state <= c_IDLE;
                    end else if (r_count == c_LAST) begin
                        r_result <= w_final;
                        r_dbz    <= 1'b0;
                        r_valid  <= 1'b1;
                        r_state  <= c_DONE;
                    end else begin
                        r_count <= r_count + c_CNT_W'(1);
                        if (r_op[2]) begin
                            r_hi <= w_diff[DATA_WIDTH] ? w_shift[DATA_WIDTH-1:0]
                                                       : w_diff[DATA_WIDTH-1:0];
                            r_lo <= {r_lo[DATA_WIDTH-2:0], !w_diff[DATA_WIDTH]};
                        end else begin
                            r_hi <= w_sum[DATA_WIDTH:1];
                            r_lo <= {w_sum[0], r_lo[DATA_WIDTH-1:1]};
                        end
                    end
                end
                c_DONE: begin
                    // Early-exit ops enter DONE with the answer parked in r_hi.
                    if (Flush) begin
                        r_valid <= 1'b0;
                        r_state <= c_IDLE;
                    end else if (!r_valid) begin
                        r_result <= r_hi;
                        r_dbz    <= r_pend_dbz;
                        r_valid  <= 1'b1;
                    end else if (Ack) begin
                        r_valid <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
